weighted_sum_seq: RTL and testbench

//   Sequential, parametrised successor to the fixed DSP-cascade weighted sum.

---
 rtl/weighted_sum_seq.sv | 156 +++++++++++++++
 tb/tb_weighted_sum_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/weighted_sum_seq.sv
// Sequential perceptron core: folds N signed products through LANES multipliers into a wide accumulator.
// Optional WEIGHTED_SUM_RELU_EN clamps negative (saturated) results to zero; sat still reports clamping.
module weighted_sum_seq #(
    parameter int N     = 8,
    parameter int W     = 16,
    parameter int LANES = 2,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W*N-1:0]   x,
    input  logic [W*N-1:0]   w,
    input  logic [2*W-1:0]   bias,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] sum,
    output logic             sat
);

    localparam int BEATS  = N / LANES;
    localparam int ACC_W  = 2 * W + $clog2(N) + 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic signed [ACC_W-1:0] MAX_ACC = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_ACC = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                   state_q, state_d;
    logic [W*N-1:0]           x_q, x_d, w_q, w_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, lane_sum, acc_next;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [OUT_W-1:0]         sum_q, sum_d;
    logic                     sat_q, sat_d;
    logic                     accept, last_beat;

    function automatic logic signed [ACC_W-1:0] lane_prod(input logic signed [W-1:0] a,
                                                          input logic signed [W-1:0] b);
        logic signed [ACC_W-1:0] ae, be;
        ae = ACC_W'(a);
        be = ACC_W'(b);
        return ae * be;
    endfunction

    function automatic logic sat_flag(input logic signed [ACC_W-1:0] a);
        return (a > MAX_ACC) || (a < MIN_ACC);
    endfunction

    function automatic logic [OUT_W-1:0] sat_value(input logic signed [ACC_W-1:0] a);
        if (a > MAX_ACC)
            return MAX_ACC[OUT_W-1:0];
        else if (a < MIN_ACC)
            return MIN_ACC[OUT_W-1:0];
        else
            return a[OUT_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] post_proc(input logic [OUT_W-1:0] v);
`ifdef WEIGHTED_SUM_RELU_EN
        return v[OUT_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // The lowest LANES elements of the shifted operand registers feed the multipliers each beat.
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++)
            lane_sum = lane_sum + lane_prod(x_q[l*W +: W], w_q[l*W +: W]);
    end

    assign acc_next  = acc_q + lane_sum;
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCUM;
            ACCUM:   if (last_beat) state_d = DONE;
            DONE:    if (out_ready) state_d = accept ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready = ~rst;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready & ~rst;
            end
            default: ;
        endcase
    end

    always_comb begin
        x_d    = x_q;
        w_d    = w_q;
        acc_d  = acc_q;
        beat_d = beat_q;
        sum_d  = sum_q;
        sat_d  = sat_q;
        if (accept) begin
            x_d    = x;
            w_d    = w;
            acc_d  = ACC_W'($signed(bias));
            beat_d = '0;
        end else if (state_q == ACCUM) begin
            x_d    = x_q >> (LANES * W);
            w_d    = w_q >> (LANES * W);
            acc_d  = acc_next;
            beat_d = beat_q + BEAT_W'(1);
            if (last_beat) begin
                sum_d = post_proc(sat_value(acc_next));
                sat_d = sat_flag(acc_next);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            beat_q <= '0;
            sum_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            beat_q <= beat_d;
            sum_q  <= sum_d;
            sat_q  <= sat_d;
        end
    end

    // Operand shift registers carry pure data and need no reset.
    always_ff @(posedge clk) begin
        x_q <= x_d;
        w_q <= w_d;
    end

    assign sum = sum_q;
    assign sat = sat_q;

endmodule

// File: tb/tb_weighted_sum_seq.sv
// Directed bench for weighted_sum_seq: main LANES=2 instance plus LANES=1 and LANES=8 instances.
module tb_weighted_sum_seq;

    logic         clk;
    logic         rst;
    logic         in_valid, in_valid_l1, in_valid_l8;
    logic         out_ready, out_ready_v;
    logic [127:0] x, w;
    logic [31:0]  bias;

    logic         in_ready, out_valid, sat;
    logic [31:0]  sum;
    logic         rdy_l1, ov_l1, sat_l1;
    logic [31:0]  sum_l1;
    logic         rdy_l8, ov_l8, sat_l8;
    logic [31:0]  sum_l8;

    int n_checks = 0;
    int n_fail   = 0;

    weighted_sum_seq #(.N(8), .W(16), .LANES(2), .OUT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .w(w), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .sat(sat)
    );

    weighted_sum_seq #(.N(8), .W(16), .LANES(1), .OUT_W(32)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_l1), .in_ready(rdy_l1),
        .x(x), .w(w), .bias(bias), .out_valid(ov_l1), .out_ready(out_ready_v),
        .sum(sum_l1), .sat(sat_l1)
    );

    weighted_sum_seq #(.N(8), .W(16), .LANES(8), .OUT_W(32)) u_l8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_l8), .in_ready(rdy_l8),
        .x(x), .w(w), .bias(bias), .out_valid(ov_l8), .out_ready(out_ready_v),
        .sum(sum_l8), .sat(sat_l8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_out(input logic [31:0] v);
`ifdef WEIGHTED_SUM_RELU_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [15:0] xv, input logic [15:0] wv, input logic [31:0] b);
        for (int i = 0; i < 8; i++) begin
            x[16*i +: 16] = xv;
            w[16*i +: 16] = wv;
        end
        bias = b;
    endtask

    task automatic send_wait(output int lat);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int  lat;
        logic seen;
        rst = 1'b1;
        in_valid = 1'b0; in_valid_l1 = 1'b0; in_valid_l8 = 1'b0;
        out_ready = 1'b0; out_ready_v = 1'b1;
        set_all(16'd0, 16'd0, 32'd0);

        #12;
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_sat", sat, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("post_reset_in_ready", in_ready, 1);

        // Test 1: all ones
        set_all(16'd1, 16'd1, 32'd0);
        send_wait(lat);
        check("t1_latency", lat, 4);
        check("t1_out_valid", out_valid, 1);
        check("t1_sum", sum, exp_out(32'd8));
        check("t1_sat", sat, 0);
        consume();
        check("t1_after_consume_valid", out_valid, 0);
        check("t1_after_consume_ready", in_ready, 1);

        // Test 2: positive and negative saturation
        set_all(16'h8000, 16'h8000, 32'd0);
        send_wait(lat);
        check("t2a_sum", sum, exp_out(32'h7FFF_FFFF));
        check("t2a_sat", sat, 1);
        consume();
        set_all(16'h8000, 16'h7FFF, 32'd0);
        send_wait(lat);
        check("t2b_sum", sum, exp_out(32'h8000_0000));
        check("t2b_sat", sat, 1);
        consume();

        // Saturation boundaries around the bias
        set_all(16'd1, 16'd1, 32'h7FFF_FFF0);
        send_wait(lat);
        check("max_inside_sum", sum, exp_out(32'h7FFF_FFF8));
        check("max_inside_sat", sat, 0);
        consume();
        set_all(16'd1, 16'd1, 32'h7FFF_FFF8);
        send_wait(lat);
        check("max_over_sum", sum, exp_out(32'h7FFF_FFFF));
        check("max_over_sat", sat, 1);
        consume();
        set_all(16'd1, 16'hFFFF, 32'h8000_0008);
        send_wait(lat);
        check("min_exact_sum", sum, exp_out(32'h8000_0000));
        check("min_exact_sat", sat, 0);
        consume();

        // Test 5: negative result
        set_all(16'd1, 16'hFFFF, 32'hFFFF_FFFB);
        send_wait(lat);
        check("t5_sum", sum, exp_out(32'hFFFF_FFF3));
        check("t5_sat", sat, 0);
        consume();

        // Distinct elements: sum of squares 1..8 = 204, plus bias 100
        for (int i = 0; i < 8; i++) begin
            x[16*i +: 16] = 16'(i + 1);
            w[16*i +: 16] = 16'(i + 1);
        end
        bias = 32'd100;
        send_wait(lat);
        check("ramp_sum", sum, exp_out(32'd304));
        check("ramp_sat", sat, 0);
        consume();

        // Test 3: backpressure, then back-to-back accept
        set_all(16'd1, 16'd1, 32'd0);
        send_wait(lat);
        set_all(16'd9, 16'd9, 32'd9);
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (!out_valid || sum !== exp_out(32'd8) || in_ready !== 1'b0) seen = 1'b1;
            tick();
        end
        check("t3_hold_stable", seen, 0);
        set_all(16'd2, 16'd3, 32'd0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        #1;
        check("t3_ready_follows_out_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("t3_accepted_valid_low", out_valid, 0);
        check("t3_accepted_ready_low", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("t3_latency", lat, 4);
        check("t3_sum", sum, exp_out(32'd48));
        consume();

        // Test 4: reset mid-accumulation
        set_all(16'd1, 16'd1, 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("t4_rst_out_valid", out_valid, 0);
        check("t4_rst_sum", sum, 0);
        check("t4_rst_sat", sat, 0);
        check("t4_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("t4_release_in_ready", in_ready, 1);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("t4_no_stale_result", seen, 0);

        // Test 6: LANES=1 and LANES=8 variants
        set_all(16'd1, 16'd1, 32'd0);
        in_valid_l1 = 1'b1;
        tick();
        in_valid_l1 = 1'b0;
        lat = 0;
        while (!ov_l1 && lat < 40) begin
            tick();
            lat++;
        end
        check("t6_l1_latency", lat, 8);
        check("t6_l1_sum", sum_l1, exp_out(32'd8));
        tick();
        in_valid_l8 = 1'b1;
        tick();
        in_valid_l8 = 1'b0;
        lat = 0;
        while (!ov_l8 && lat < 40) begin
            tick();
            lat++;
        end
        check("t6_l8_latency", lat, 1);
        check("t6_l8_sum", sum_l8, exp_out(32'd8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
